// File: rtl/spectrum_peak_hold.sv
// Per-bin alpha-max-beta-min magnitude with decaying peak-hold, published
// frame by frame through a ping-pong display buffer.
module spectrum_peak_hold #(
  parameter int unsigned MAG_W       = 8,
  parameter int unsigned NUM_BINS    = 64,
  parameter int unsigned BIN_AW      = 6,
  parameter int unsigned DECAY_SHIFT = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [MAG_W-1:0]  re_abs,
  input  logic [MAG_W-1:0]  im_abs,
  input  logic              in_last,
  input  logic [BIN_AW-1:0] rd_addr,
  output logic [MAG_W:0]    rd_data,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned PW = MAG_W + 1;
  localparam logic [BIN_AW-1:0] LAST_BIN = BIN_AW'(NUM_BINS - 1);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_SWAP1 = 2'd2,
    S_SWAP2 = 2'd3
  } state_t;

  state_t state, state_next;

  logic [PW-1:0] hold_mem  [NUM_BINS];
  logic [PW-1:0] bank0_mem [NUM_BINS];
  logic [PW-1:0] bank1_mem [NUM_BINS];

  logic [BIN_AW-1:0] clr_idx;
  logic [BIN_AW-1:0] bin_idx;
  logic              disp_bank;
  logic              err_pend;

  logic              s1_valid;
  logic [BIN_AW-1:0] s1_addr;
  logic [PW-1:0]     s1_mag;
  logic              s1_bank;
  logic [PW-1:0]     s1_old;

  logic              accept_c;
  logic              last_bin_c;
  logic              close_c;
  logic [MAG_W-1:0]  mx_c;
  logic [MAG_W-1:0]  mn_c;
  logic [PW-1:0]     mag_c;
  logic [PW-1:0]     decayed_c;
  logic [PW-1:0]     new_c;

  // Accept / frame-close decode and magnitude/peak datapath
  always_comb begin
    accept_c   = in_valid && in_ready;
    last_bin_c = (bin_idx == LAST_BIN);
    close_c    = accept_c && (in_last || last_bin_c);
    mx_c       = (re_abs >= im_abs) ? re_abs : im_abs;
    mn_c       = (re_abs >= im_abs) ? im_abs : re_abs;
    mag_c      = PW'(mx_c) + PW'(mn_c >> 1);
    decayed_c  = s1_old - (s1_old >> DECAY_SHIFT);
    new_c      = (s1_mag >= decayed_c) ? s1_mag : decayed_c;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_CLEAR: if (clr_idx == LAST_BIN) state_next = S_RUN;
      S_RUN:   if (close_c) state_next = S_SWAP1;
      S_SWAP1: state_next = S_SWAP2;
      S_SWAP2: state_next = S_RUN;
      default: state_next = S_CLEAR;
    endcase
  end

  // State, control and pipeline registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_CLEAR;
      clr_idx    <= '0;
      bin_idx    <= '0;
      disp_bank  <= 1'b0;
      err_pend   <= 1'b0;
      in_ready   <= 1'b0;
      frame_done <= 1'b0;
      frame_err  <= 1'b0;
      s1_valid   <= 1'b0;
      s1_addr    <= '0;
      s1_mag     <= '0;
      s1_bank    <= 1'b0;
      rd_data    <= '0;
    end else begin
      state      <= state_next;
      in_ready   <= (state_next == S_RUN);
      frame_done <= (state == S_SWAP1);
      frame_err  <= (state == S_SWAP1) && err_pend;
      clr_idx    <= (state == S_CLEAR) ? clr_idx + BIN_AW'(1) : '0;
      s1_valid   <= accept_c;
      if (accept_c) begin
        s1_addr <= bin_idx;
        s1_mag  <= mag_c;
        s1_bank <= ~disp_bank;
        bin_idx <= close_c ? '0 : bin_idx + BIN_AW'(1);
      end
      if (close_c) err_pend <= in_last && !last_bin_c;
      if (state == S_SWAP2) disp_bank <= ~disp_bank;
      rd_data <= disp_bank ? bank1_mem[rd_addr] : bank0_mem[rd_addr];
    end
  end

  // Memories: CLEAR sweep has priority; otherwise the stage-2 peak write
  always_ff @(posedge clk) begin
    s1_old <= hold_mem[bin_idx];
    if (state == S_CLEAR) begin
      hold_mem[clr_idx]  <= '0;
      bank0_mem[clr_idx] <= '0;
      bank1_mem[clr_idx] <= '0;
    end else if (s1_valid) begin
      hold_mem[s1_addr] <= new_c;
      if (s1_bank) bank1_mem[s1_addr] <= new_c;
      else         bank0_mem[s1_addr] <= new_c;
    end
  end

endmodule

// File: tb/tb_spectrum_peak_hold.sv
// Bench for spectrum_peak_hold: table-driven magnitude vectors plus randomized
// frames compared against an array-based model of the peak-hold banks.
module tb_spectrum_peak_hold;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] re_abs;
  logic [7:0] im_abs;
  logic       in_last;
  logic [5:0] rd_addr;
  logic [8:0] rd_data;
  logic       frame_done;
  logic       frame_err;

  spectrum_peak_hold #(.MAG_W(8), .NUM_BINS(64), .BIN_AW(6), .DECAY_SHIFT(3)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .re_abs(re_abs), .im_abs(im_abs), .in_last(in_last), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_done(frame_done), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int mag;
  } vec_t;

  localparam int NV = 10;
  vec_t tbl [NV];

  int n_vec = 0;
  int n_err = 0;

  int hold_m [64];
  int bank_m [2][64];
  int disp_m;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      hold_m[i] = 0;
      bank_m[0][i] = 0;
      bank_m[1][i] = 0;
    end
    disp_m = 0;
  endtask

  task automatic model_update(input int b, input int re, input int im);
    int mx, mn, m, dec, nv;
    mx  = (re > im) ? re : im;
    mn  = (re > im) ? im : re;
    m   = mx + mn / 2;
    dec = hold_m[b] - hold_m[b] / 8;
    nv  = (m > dec) ? m : dec;
    hold_m[b] = nv;
    bank_m[1 - disp_m][b] = nv;
  endtask

  task automatic read_check(input int a, input string name);
    rd_addr = 6'(a);
    tick();
    check(name, int'(rd_data), bank_m[disp_m][a]);
  endtask

  task automatic read_all();
    for (int a = 0; a < 64; a++) read_check(a, "rd_bin");
  endtask

  // mode 0: constant re/im, 1: zeros, 2: random, 3: table then zeros
  task automatic run_frame(input int last_at, input int mode, input int cre,
                           input int cim, input int gap_pct, input int probe);
    int bin, cyc, re, im;
    bit closed, err, v, il, acc;
    bin = 0; cyc = 0; closed = 0; err = 0;
    while (!closed && cyc < 1000) begin
      v = ($urandom_range(99) >= 32'(gap_pct));
      case (mode)
        0: begin re = cre; im = cim; end
        1: begin re = 0; im = 0; end
        2: begin re = int'($urandom_range(255)); im = int'($urandom_range(255)); end
        default: begin
          re = (bin < NV) ? tbl[bin].re : 0;
          im = (bin < NV) ? tbl[bin].im : 0;
        end
      endcase
      il = (bin == last_at);
      in_valid = v;
      re_abs   = 8'(re);
      im_abs   = 8'(im);
      in_last  = il;
      acc      = v && in_ready;
      tick();
      cyc++;
      if (acc) begin
        model_update(bin, re, im);
        if (il || bin == 63) begin
          closed = 1;
          err = il && (bin != 63);
          bin = 0;
        end else begin
          bin++;
        end
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!closed) begin
      check("frame_close_timeout", 0, 1);
      return;
    end
    check("swap1_done_low", int'(frame_done), 0);
    check("swap1_ready_low", int'(in_ready), 0);
    tick();
    check("frame_done_pulse", int'(frame_done), 1);
    check("frame_err", int'(frame_err), int'(err));
    check("swap2_ready_low", int'(in_ready), 0);
    rd_addr = 6'(probe);
    tick();
    check("ready_after_swap", int'(in_ready), 1);
    check("done_one_cycle", int'(frame_done), 0);
    check("err_one_cycle", int'(frame_err), 0);
    check("rd_in_toggle_old_bank", int'(rd_data), bank_m[disp_m][probe]);
    disp_m = 1 - disp_m;
  endtask

  task automatic count_clear(output int cycles, output int dones);
    cycles = 0; dones = 0;
    while (!in_ready && cycles < 200) begin
      tick();
      cycles++;
      if (frame_done) dones++;
    end
  endtask

  initial begin
    int cyc, dn;
    tbl[0] = '{200, 100, 250};
    tbl[1] = '{50, 255, 280};
    tbl[2] = '{255, 255, 382};
    tbl[3] = '{0, 0, 0};
    tbl[4] = '{255, 0, 255};
    tbl[5] = '{0, 255, 255};
    tbl[6] = '{1, 1, 1};
    tbl[7] = '{100, 200, 250};
    tbl[8] = '{7, 3, 8};
    tbl[9] = '{128, 129, 193};

    rst_n = 1'b0; in_valid = 1'b0; re_abs = '0; im_abs = '0; in_last = 1'b0; rd_addr = '0;
    repeat (3) tick();
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_frame_done", int'(frame_done), 0);
    check("rst_frame_err", int'(frame_err), 0);
    check("rst_rd_data", int'(rd_data), 0);
    rst_n = 1'b1;
    model_reset();
    count_clear(cyc, dn);
    check("clear_cycles", cyc, 64);
    read_check(0, "clr_rd0");
    read_check(31, "clr_rd31");
    read_check(63, "clr_rd63");

    // Table vectors on a freshly cleared hold RAM: readback equals magnitude
    run_frame(63, 3, 0, 0, 0, 2);
    for (int i = 0; i < NV; i++) begin
      rd_addr = 6'(i);
      tick();
      check("tbl_mag", int'(rd_data), tbl[i].mag);
    end
    read_all();

    // Constant frame (implicit last), then two decaying zero frames
    run_frame(-1, 0, 200, 100, 0, 40);
    read_all();
    run_frame(63, 1, 0, 0, 0, 5);
    read_all();
    run_frame(-1, 1, 0, 0, 0, 6);
    read_all();

    // Table again with random in_valid gaps
    run_frame(63, 3, 0, 0, 40, 1);
    read_all();

    // Early last at bin 10, then a full frame that must restart at bin 0
    run_frame(10, 2, 0, 0, 0, 30);
    read_all();
    run_frame(-1, 2, 0, 0, 20, 10);
    read_all();

    for (int f = 0; f < 4; f++) begin
      int la;
      la = ($urandom_range(1) == 1) ? int'($urandom_range(63)) : -1;
      run_frame(la, 2, 0, 0, 30, int'($urandom_range(63)));
      read_all();
    end

    // Reset in the middle of a frame after 20 accepted bins
    for (int i = 0; i < 20; i++) begin
      in_valid = 1'b1; re_abs = 8'(i + 50); im_abs = 8'(i); in_last = 1'b0;
      tick();
    end
    rst_n = 1'b0; in_valid = 1'b0;
    tick();
    check("midrst_done", int'(frame_done), 0);
    rst_n = 1'b1;
    model_reset();
    count_clear(cyc, dn);
    check("midrst_clear_cycles", cyc, 64);
    check("midrst_no_done", dn, 0);
    read_all();

    run_frame(63, 3, 0, 0, 10, 3);
    read_all();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
